// File: rtl/hazard_unit_mc.sv
// Hazard controller for the 5-stage MIPS pipeline (F/D/E/M/W).
// Generates the forwarding selects and the load-use and branch-operand stalls.
// Also generates the mispredict and exception flushes.
// Holds the multi-cycle divide stall sequencer and a saturating counter of stalled fetch cycles.
module hazard_unit_mc #(
    parameter int REG_AW     = 5,
    parameter int DIV_CYCLES = 4,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [REG_AW-1:0] rsD,
    input  logic [REG_AW-1:0] rtD,
    input  logic              branchD,
    input  logic [REG_AW-1:0] rsE,
    input  logic [REG_AW-1:0] rtE,
    input  logic [REG_AW-1:0] writeregE,
    input  logic              regwriteE,
    input  logic              memtoregE,
    input  logic              div_opE,
    input  logic              branch_mispredE,
    input  logic [REG_AW-1:0] writeregM,
    input  logic              regwriteM,
    input  logic              memtoregM,
    input  logic              exceptM,
    input  logic [REG_AW-1:0] writeregW,
    input  logic              regwriteW,
    input  logic              stat_clr,
    output logic              forwardaD,
    output logic              forwardbD,
    output logic [1:0]        forwardaE,
    output logic [1:0]        forwardbE,
    output logic              stallF,
    output logic              stallD,
    output logic              stallE,
    output logic              flushD,
    output logic              flushE,
    output logic              flushM,
    output logic              div_busy,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } div_state_t;

    // The divide occupies E for the IDLE cycle where it is first seen plus DIV_CYCLES-1 BUSY cycles.
    localparam logic [7:0]       CNT_LOAD = 8'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    div_state_t       state_q;
    logic [7:0]       cnt_q;
    logic [CNT_W-1:0] stall_cnt_q;

    logic lwstall;
    logic brstall;
    logic divstall;

    // Forwarding selects: the youngest producer (M) wins over W, and register 0 is never forwarded.
    always_comb begin
        forwardaE = 2'b00;
        forwardbE = 2'b00;
        if (rsE != '0 && rsE == writeregM && regwriteM)
            forwardaE = 2'b10;
        else if (rsE != '0 && rsE == writeregW && regwriteW)
            forwardaE = 2'b01;
        if (rtE != '0 && rtE == writeregM && regwriteM)
            forwardbE = 2'b10;
        else if (rtE != '0 && rtE == writeregW && regwriteW)
            forwardbE = 2'b01;
        forwardaD = (rsD != '0) && (rsD == writeregM) && regwriteM;
        forwardbD = (rtD != '0) && (rtD == writeregM) && regwriteM;
    end

    // Stall and flush generation; a committed exception overrides every stall.
    always_comb begin
        lwstall  = memtoregE && (rtE != '0) && ((rtE == rsD) || (rtE == rtD));
        brstall  = branchD &&
                   ((regwriteE && (writeregE != '0) && ((writeregE == rsD) || (writeregE == rtD))) ||
                    (memtoregM && (writeregM != '0) && ((writeregM == rsD) || (writeregM == rtD))));
        divstall = (state_q == S_IDLE) ? div_opE : (state_q == S_BUSY);
        if (exceptM) begin
            stallF = 1'b0;
            stallD = 1'b0;
            stallE = 1'b0;
            flushD = 1'b1;
            flushE = 1'b1;
            flushM = 1'b1;
        end else begin
            stallE = divstall;
            stallD = divstall | lwstall | brstall;
            stallF = divstall | lwstall | brstall;
            // The bubble into E is only meaningful when E itself advances.
            flushE = (lwstall | brstall) & ~divstall;
            // While E is held, M receives a bubble each cycle.
            flushM = divstall;
            // D holds wrong-path work after a mispredict, so other D stalls do not matter.
            flushD = branch_mispredE & ~divstall;
        end
    end

    // Divide sequencer: IDLE -> BUSY (count down) -> DONE -> IDLE; exceptions abort to IDLE.
    always_ff @(posedge clk) begin
        if (!resetn || exceptM) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (div_opE) begin
                        state_q <= S_BUSY;
                        cnt_q   <= CNT_LOAD;
                    end
                end
                S_BUSY: begin
                    if (cnt_q == 8'd1) begin
                        state_q <= S_DONE;
                        cnt_q   <= 8'd0;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= 8'd0;
                end
            endcase
        end
    end

    // Saturating count of cycles with fetch stalled; a clear takes precedence over counting.
    always_ff @(posedge clk) begin
        if (!resetn || stat_clr)
            stall_cnt_q <= '0;
        else if (stallF && stall_cnt_q != CNT_MAX)
            stall_cnt_q <= stall_cnt_q + 1'b1;
    end

    assign div_busy  = (state_q != S_IDLE);
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Self-checking bench for hazard_unit_mc.
// Instance u0 uses DIV_CYCLES=4 and CNT_W=16. Instance u1 uses DIV_CYCLES=3 and CNT_W=3.
// Both instances share the same stimulus.
module tb_hazard_unit_mc;

    logic       clk;
    logic       resetn;
    logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
    logic       branchD, regwriteE, memtoregE, div_opE, branch_mispredE;
    logic       regwriteM, memtoregM, exceptM, regwriteW, stat_clr;

    logic        forwardaD, forwardbD, stallF, stallD, stallE, flushD, flushE, flushM, div_busy;
    logic [1:0]  forwardaE, forwardbE;
    logic [15:0] stall_cnt;

    logic        b_forwardaD, b_forwardbD, b_stallF, b_stallD, b_stallE, b_flushD, b_flushE, b_flushM, b_div_busy;
    logic [1:0]  b_forwardaE, b_forwardbE;
    logic [2:0]  b_stall_cnt;

    int checks = 0;
    int errors = 0;

    hazard_unit_mc #(.REG_AW(5), .DIV_CYCLES(4), .CNT_W(16)) u0 (
        .clk(clk), .resetn(resetn), .rsD(rsD), .rtD(rtD), .branchD(branchD),
        .rsE(rsE), .rtE(rtE), .writeregE(writeregE), .regwriteE(regwriteE),
        .memtoregE(memtoregE), .div_opE(div_opE), .branch_mispredE(branch_mispredE),
        .writeregM(writeregM), .regwriteM(regwriteM), .memtoregM(memtoregM),
        .exceptM(exceptM), .writeregW(writeregW), .regwriteW(regwriteW), .stat_clr(stat_clr),
        .forwardaD(forwardaD), .forwardbD(forwardbD), .forwardaE(forwardaE), .forwardbE(forwardbE),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .flushD(flushD), .flushE(flushE),
        .flushM(flushM), .div_busy(div_busy), .stall_cnt(stall_cnt)
    );

    hazard_unit_mc #(.REG_AW(5), .DIV_CYCLES(3), .CNT_W(3)) u1 (
        .clk(clk), .resetn(resetn), .rsD(rsD), .rtD(rtD), .branchD(branchD),
        .rsE(rsE), .rtE(rtE), .writeregE(writeregE), .regwriteE(regwriteE),
        .memtoregE(memtoregE), .div_opE(div_opE), .branch_mispredE(branch_mispredE),
        .writeregM(writeregM), .regwriteM(regwriteM), .memtoregM(memtoregM),
        .exceptM(exceptM), .writeregW(writeregW), .regwriteW(regwriteW), .stat_clr(stat_clr),
        .forwardaD(b_forwardaD), .forwardbD(b_forwardbD), .forwardaE(b_forwardaE), .forwardbE(b_forwardbE),
        .stallF(b_stallF), .stallD(b_stallD), .stallE(b_stallE), .flushD(b_flushD), .flushE(b_flushE),
        .flushM(b_flushM), .div_busy(b_div_busy), .stall_cnt(b_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic clear_inputs();
        rsD = 0; rtD = 0; branchD = 0; rsE = 0; rtE = 0; writeregE = 0;
        regwriteE = 0; memtoregE = 0; div_opE = 0; branch_mispredE = 0;
        writeregM = 0; regwriteM = 0; memtoregM = 0; exceptM = 0;
        writeregW = 0; regwriteW = 0; stat_clr = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        logic [12:0] outs;
        do_reset();
        @(negedge clk);
        outs = {forwardaD, forwardbD, forwardaE, forwardbE, stallF, stallD, stallE,
                flushD, flushE, flushM, div_busy};
        checks++;
        if (outs !== 13'd0 || stall_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b cnt=%0d, expected all zero", outs, stall_cnt);
        end
        checks++;
        if (b_stall_cnt !== 3'd0 || b_div_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_u1: got cnt=%0d busy=%b, expected 0 0", b_stall_cnt, b_div_busy);
        end
        $display("test_reset done");
        tick();
    endtask

    task automatic test_div_sequence();
        logic [3:0] exp_v;
        logic [3:0] got_v;
        logic       exp_b;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            div_opE = (c < 5);
            @(negedge clk);
            exp_v = {(c < 4), (c < 4), (c < 4), (c >= 1 && c <= 4)};
            got_v = {stallF, stallE, flushM, div_busy};
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL div_seq cycle %0d: got stallF/E/flushM/busy=%b, expected %b", c, got_v, exp_v);
            end
            // u1 (3 cycles) sees the held request again after its one free cycle.
            exp_b = (c != 3);
            checks++;
            if (b_stallE !== exp_b) begin
                errors++;
                $display("FAIL div_seq_u1 cycle %0d: got stallE=%b, expected %b", c, b_stallE, exp_b);
            end
            $display("div cycle %0d: stallF=%b stallE=%b flushM=%b busy=%b cnt=%0d", c, stallF, stallE, flushM, div_busy, stall_cnt);
            if (c == 5) begin
                checks++;
                if (stall_cnt !== 16'd4) begin
                    errors++;
                    $display("FAIL div_stall_cnt: got %0d, expected 4", stall_cnt);
                end
            end
            tick();
        end
    endtask

    task automatic test_loaduse();
        logic [3:0] got_v;
        do_reset();
        memtoregE = 1; rtE = 5; rsD = 5;
        @(negedge clk);
        got_v = {stallF, stallD, flushE, stallE};
        checks++;
        if (got_v !== 4'b1110) begin
            errors++;
            $display("FAIL loaduse_hit: got stallF/D/flushE/stallE=%b, expected 1110", got_v);
        end
        $display("loaduse rtE=5 rsD=5: %b", got_v);
        tick();
        rtE = 0; rsD = 0;
        @(negedge clk);
        got_v = {stallF, stallD, flushE, stallE};
        checks++;
        if (got_v !== 4'b0000) begin
            errors++;
            $display("FAIL loaduse_r0: got %b, expected 0000", got_v);
        end
        $display("loaduse rtE=0 rsD=0: %b", got_v);
        tick();
    endtask

    task automatic test_forwarding();
        do_reset();
        rsE = 3; rtE = 3; rsD = 3; writeregM = 3; regwriteM = 1; writeregW = 3; regwriteW = 1;
        @(negedge clk);
        checks++;
        if (forwardaE !== 2'b10 || forwardbE !== 2'b10 || forwardaD !== 1'b1) begin
            errors++;
            $display("FAIL fwd_m: got aE=%b bE=%b aD=%b, expected 10 10 1", forwardaE, forwardbE, forwardaD);
        end
        $display("fwd M+W: aE=%b bE=%b aD=%b", forwardaE, forwardbE, forwardaD);
        tick();
        regwriteM = 0;
        @(negedge clk);
        checks++;
        if (forwardaE !== 2'b01 || forwardbE !== 2'b01 || forwardaD !== 1'b0) begin
            errors++;
            $display("FAIL fwd_w: got aE=%b bE=%b aD=%b, expected 01 01 0", forwardaE, forwardbE, forwardaD);
        end
        $display("fwd W only: aE=%b bE=%b", forwardaE, forwardbE);
        tick();
        rsE = 0;
        @(negedge clk);
        checks++;
        if (forwardaE !== 2'b00 || forwardbE !== 2'b01) begin
            errors++;
            $display("FAIL fwd_r0: got aE=%b bE=%b, expected 00 01", forwardaE, forwardbE);
        end
        $display("fwd rsE=0: aE=%b", forwardaE);
        tick();
        branchD = 1; regwriteE = 1; writeregE = 7; rtD = 7;
        @(negedge clk);
        checks++;
        if (stallD !== 1'b1 || flushE !== 1'b1 || stallE !== 1'b0) begin
            errors++;
            $display("FAIL brstall: got stallD=%b flushE=%b stallE=%b, expected 1 1 0", stallD, flushE, stallE);
        end
        $display("brstall: stallD=%b flushE=%b", stallD, flushE);
        tick();
    endtask

    task automatic test_exception();
        logic [6:0] got_v;
        do_reset();
        for (int c = 0; c < 4; c++) begin
            div_opE = (c < 3);
            exceptM = (c == 2);
            @(negedge clk);
            if (c == 2) begin
                got_v = {stallF, stallD, stallE, flushD, flushE, flushM, div_busy};
                checks++;
                if (got_v !== 7'b0001111) begin
                    errors++;
                    $display("FAIL except_busy: got stallFDE/flushDEM/busy=%b, expected 0001111", got_v);
                end
            end
            if (c == 3) begin
                got_v = {stallF, stallD, stallE, flushD, flushE, flushM, div_busy};
                checks++;
                if (got_v !== 7'b0000000 || stall_cnt !== 16'd2) begin
                    errors++;
                    $display("FAIL except_after: got %b cnt=%0d, expected 0000000 cnt=2", got_v, stall_cnt);
                end
            end
            $display("except cycle %0d: stallF=%b flushM=%b busy=%b", c, stallF, flushM, div_busy);
            tick();
        end
    endtask

    task automatic test_mispredict();
        do_reset();
        branch_mispredE = 1;
        @(negedge clk);
        checks++;
        if (flushD !== 1'b1) begin
            errors++;
            $display("FAIL mispred_flush: got flushD=%b, expected 1", flushD);
        end
        $display("mispredict: flushD=%b", flushD);
        div_opE = 1;
        #1;
        checks++;
        if (flushD !== 1'b0 || stallE !== 1'b1 || flushM !== 1'b1) begin
            errors++;
            $display("FAIL mispred_div: got flushD=%b stallE=%b flushM=%b, expected 0 1 1", flushD, stallE, flushM);
        end
        $display("mispredict+div: flushD=%b stallE=%b", flushD, stallE);
        tick();
    endtask

    task automatic test_counter_saturation();
        do_reset();
        memtoregE = 1; rtE = 5; rsD = 5;
        repeat (10) tick();
        @(negedge clk);
        checks++;
        if (b_stall_cnt !== 3'd7 || stall_cnt !== 16'd10) begin
            errors++;
            $display("FAIL cnt_sat: got u1=%0d u0=%0d, expected 7 10", b_stall_cnt, stall_cnt);
        end
        $display("saturation: u1=%0d u0=%0d", b_stall_cnt, stall_cnt);
        tick();
        stat_clr = 1;
        tick();
        stat_clr = 0;
        @(negedge clk);
        checks++;
        if (b_stall_cnt !== 3'd0 || stall_cnt !== 16'd0) begin
            errors++;
            $display("FAIL cnt_clr: got u1=%0d u0=%0d, expected 0 0", b_stall_cnt, stall_cnt);
        end
        tick();
        @(negedge clk);
        checks++;
        if (b_stall_cnt !== 3'd1 || stall_cnt !== 16'd1) begin
            errors++;
            $display("FAIL cnt_resume: got u1=%0d u0=%0d, expected 1 1", b_stall_cnt, stall_cnt);
        end
        $display("after clear: u1=%0d u0=%0d", b_stall_cnt, stall_cnt);
        tick();
    endtask

    task automatic test_reset_mid_busy();
        do_reset();
        div_opE = 1;
        tick();
        div_opE = 0;
        @(negedge clk);
        checks++;
        if (div_busy !== 1'b1 || stallE !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_pre: got busy=%b stallE=%b, expected 1 1", div_busy, stallE);
        end
        resetn = 0;
        tick();
        resetn = 1;
        @(negedge clk);
        checks++;
        if (div_busy !== 1'b0 || stallF !== 1'b0 || stall_cnt !== 16'd0 || b_div_busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_post: got busy=%b stallF=%b cnt=%0d busy_u1=%b, expected 0 0 0 0",
                     div_busy, stallF, stall_cnt, b_div_busy);
        end
        $display("reset mid-busy: busy=%b cnt=%0d", div_busy, stall_cnt);
        tick();
    endtask

    // Reference model: a divide is tracked as the number of cycles the sequencer remains non-idle.
    task automatic test_random();
        int rem0, rem1, cnt0, cnt1;
        int fa, fb;
        bit lw, br, ds0, ds1, fad, fbd;
        bit sF0, sF1, sE0, fD0, fE0, fM0;
        logic [11:0] exp_v, got_v;
        logic [2:0]  exp_b, got_b;
        do_reset();
        rem0 = 0; rem1 = 0; cnt0 = 0; cnt1 = 0;
        for (int n = 0; n < 400; n++) begin
            rsD = 5'($urandom_range(0, 3)); rtD = 5'($urandom_range(0, 3));
            rsE = 5'($urandom_range(0, 3)); rtE = 5'($urandom_range(0, 3));
            writeregE = 5'($urandom_range(0, 3)); writeregM = 5'($urandom_range(0, 3));
            writeregW = 5'($urandom_range(0, 3));
            branchD = $urandom_range(0, 1); regwriteE = $urandom_range(0, 1);
            memtoregE = ($urandom_range(0, 3) == 0); div_opE = ($urandom_range(0, 3) == 0);
            branch_mispredE = ($urandom_range(0, 3) == 0);
            regwriteM = $urandom_range(0, 1); memtoregM = $urandom_range(0, 1);
            regwriteW = $urandom_range(0, 1);
            exceptM = ($urandom_range(0, 15) == 0);
            stat_clr = ($urandom_range(0, 31) == 0);
            resetn = ($urandom_range(0, 47) != 0);

            fa = (rsE != 0 && rsE == writeregM && regwriteM) ? 2 : (rsE != 0 && rsE == writeregW && regwriteW) ? 1 : 0;
            fb = (rtE != 0 && rtE == writeregM && regwriteM) ? 2 : (rtE != 0 && rtE == writeregW && regwriteW) ? 1 : 0;
            fad = (rsD != 0 && rsD == writeregM && regwriteM);
            fbd = (rtD != 0 && rtD == writeregM && regwriteM);
            lw = memtoregE && rtE != 0 && (rtE == rsD || rtE == rtD);
            br = branchD && ((regwriteE && writeregE != 0 && (writeregE == rsD || writeregE == rtD)) ||
                             (memtoregM && writeregM != 0 && (writeregM == rsD || writeregM == rtD)));
            ds0 = (rem0 == 0) ? div_opE : (rem0 > 1);
            ds1 = (rem1 == 0) ? div_opE : (rem1 > 1);
            if (exceptM) begin
                sF0 = 0; sE0 = 0; fD0 = 1; fE0 = 1; fM0 = 1; sF1 = 0;
            end else begin
                sF0 = ds0 || lw || br; sE0 = ds0;
                fD0 = branch_mispredE && !ds0; fE0 = (lw || br) && !ds0; fM0 = ds0;
                sF1 = ds1 || lw || br;
            end
            exp_v = {fad, fbd, 2'(fa), 2'(fb), sF0, sF0, sE0, fD0, fE0, fM0};
            exp_b = {sF1, (rem1 != 0), 1'b0};

            @(negedge clk);
            got_v = {forwardaD, forwardbD, forwardaE, forwardbE, stallF, stallD, stallE, flushD, flushE, flushM};
            got_b = {b_stallF, b_div_busy, 1'b0};
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL rand_outs #%0d: got %b, expected %b", n, got_v, exp_v);
            end
            checks++;
            if (div_busy !== (rem0 != 0) || stall_cnt !== 16'(cnt0)) begin
                errors++;
                $display("FAIL rand_state_u0 #%0d: got busy=%b cnt=%0d, expected busy=%0d cnt=%0d",
                         n, div_busy, stall_cnt, (rem0 != 0), cnt0);
            end
            checks++;
            if (got_b !== exp_b || b_stall_cnt !== 3'(cnt1)) begin
                errors++;
                $display("FAIL rand_u1 #%0d: got stallF/busy=%b cnt=%0d, expected %b cnt=%0d",
                         n, got_b[2:1], b_stall_cnt, exp_b[2:1], cnt1);
            end
            $display("rand #%0d: outs=%b busy=%b cnt=%0d u1cnt=%0d", n, got_v, div_busy, stall_cnt, b_stall_cnt);

            if (!resetn || exceptM) rem0 = 0;
            else if (rem0 == 0) rem0 = div_opE ? 4 : 0;
            else rem0--;
            if (!resetn || exceptM) rem1 = 0;
            else if (rem1 == 0) rem1 = div_opE ? 3 : 0;
            else rem1--;
            if (!resetn || stat_clr) cnt0 = 0;
            else if (sF0 && cnt0 < 65535) cnt0++;
            if (!resetn || stat_clr) cnt1 = 0;
            else if (sF1 && cnt1 < 7) cnt1++;
            tick();
        end
        resetn = 1;
    endtask

    initial begin
        clear_inputs();
        resetn = 1'b0;
        tick();
        tick();
        test_reset();
        test_div_sequence();
        test_loaduse();
        test_forwarding();
        test_exception();
        test_mispredict();
        test_counter_saturation();
        test_reset_mid_busy();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_unit_mc.md
Name: hazard_unit_mc

Overview:
- Parametrised next-generation pipeline hazard controller for the 5-stage MIPS core (F/D/E/M/W).
- Provides E-stage and D-stage (branch compare) forwarding, load-use and branch-operand stalls, and branch-mispredict and M-stage exception flushes.
- Adds a sequential multi-cycle divider stall sequencer and a saturating stall-cycle performance counter.
- Combinational hazard outputs; FSM, divide counter and stall counter are registered.

Parameters:
- REG_AW, 5, register-index width (NREGS = 2**REG_AW; index 0 is hardwired zero, never forwarded or stalled on).
- DIV_CYCLES, 4, total E-stage stall cycles for one div/divu; legal range 2..255.
- CNT_W, 16, width of the stall performance counter.

Ports:
- clk  in  1  core clock; all state updates on rising edge
- resetn  in  1  synchronous active-low reset
- rsD, rtD  in  REG_AW  D-stage source indices
- branchD  in  1  D-stage instruction is a branch compared in D
- rsE, rtE  in  REG_AW  E-stage source indices
- writeregE  in  REG_AW  E-stage destination
- regwriteE  in  1  E-stage writes register
- memtoregE  in  1  E-stage instruction is a load
- div_opE  in  1  level: E-stage instruction is div/divu
- branch_mispredE  in  1  branch resolved in E was mispredicted
- writeregM  in  REG_AW  M-stage destination
- regwriteM, memtoregM  in  1 each  M-stage write enable / load flag
- exceptM  in  1  exception committed in M
- writeregW  in  REG_AW  W-stage destination
- regwriteW  in  1  W-stage write enable
- stat_clr  in  1  synchronous clear of stall_cnt
- forwardaD, forwardbD  out  1 each  select M-stage result for D compare
- forwardaE, forwardbE  out  2 each  00 regfile, 10 from M, 01 from W
- stallF, stallD, stallE  out  1 each  hold stage register
- flushD, flushE, flushM  out  1 each  insert bubble into stage register
- div_busy  out  1  divider sequencer not IDLE
- stall_cnt  out  CNT_W  saturating count of cycles with stallF=1

Behaviour:
- Forwarding (pure combinational): forwardaE=10 when rsE!=0, rsE==writeregM, regwriteM; else 01 when rsE==writeregW, regwriteW; else 00. M has priority over W. Same rule for forwardbE with rtE. forwardaD=(rsD!=0)&(rsD==writeregM)&regwriteM; same for forwardbD with rtD.
- lwstall = memtoregE & (rtE!=0) & (rtE==rsD | rtE==rtD).
- brstall = branchD & ((regwriteE & writeregE!=0 & (writeregE==rsD | writeregE==rtD)) | (memtoregM & writeregM!=0 & (writeregM==rsD | writeregM==rtD))).
- Divider FSM states are IDLE, BUSY and DONE; an internal counter cnt is 8 bits wide.
  - IDLE: divstall=div_opE. If div_opE, go to BUSY and load cnt=DIV_CYCLES-1.
  - BUSY: divstall=1. If cnt==1, go to DONE; else cnt=cnt-1.
  - DONE: divstall=0, so the divide leaves E this cycle. Unconditionally go to IDLE; div_opE is ignored in DONE.
  - Stall length: exactly DIV_CYCLES cycles per divide. Back-to-back divides each stall DIV_CYCLES cycles with one free cycle between.
  - div_busy = (state != IDLE).
- Output equations, with exceptM dominant:
  - exceptM=1: stallF=stallD=stallE=0; flushD=flushE=flushM=1; FSM forced to IDLE next cycle with cnt=0.
  - Otherwise:
    - stallE = divstall.
    - stallD = stallF = divstall | lwstall | brstall.
    - flushE = (lwstall | brstall) & ~divstall (bubble only when E advances).
    - flushM = divstall (bubble into M while E is held).
    - flushD = branch_mispredE & ~divstall. A concurrent lwstall/brstall is irrelevant because the D contents are wrong-path.
- stall_cnt:
  - resetn=0 or stat_clr=1: cleared to 0 next edge (stat_clr wins over increment).
  - Otherwise increments by 1 each cycle stallF=1.
  - Saturates at 2**CNT_W-1 with no wrap.
- Reset: synchronous on resetn=0 → FSM IDLE, cnt=0, stall_cnt=0. A reset during BUSY aborts the sequence; the next cycle is IDLE.
- Outputs are combinational from inputs and state. After reset with all inputs 0, every output is 0.

Test Plan:
- DIV_CYCLES=4, div_opE held high from cycle 0 → stallF/D/E=1 and flushM=1 in cycles 0–3; cycle 4 (DONE) stallE=0, div_busy=1; cycle 5 div_busy=0; stall_cnt=4.
- memtoregE=1, rtE=5, rsD=5 → stallF=stallD=flushE=1, stallE=0; then rtE=0 with rsD=0 → no stall.
- rsE=3, writeregM=3, regwriteM=1, writeregW=3, regwriteW=1 → forwardaE=10; drop regwriteM → 01; rsE=0 → 00; branchD=1, regwriteE=1, writeregE=rtD=7 → stallD=1, flushE=1.
- exceptM=1 during BUSY (cycle 2) → stalls 0, flushD=flushE=flushM=1 that cycle; next cycle div_busy=0 and no stall with div_opE=0.
- branch_mispredE=1 with divstall=0 → flushD=1; together with div_opE=1 from IDLE → flushD=0, stallE=1.
- CNT_W=3, stallF held high 10 cycles → stall_cnt=7 (saturated); stat_clr=1 → 0; resetn=0 mid-BUSY → next cycle IDLE, stall_cnt=0.
